// File: rtl/fc84_vector_loader.sv
// Collects N activation/weight beat pairs into flattened vectors for an FC layer,
// holds them stable until the consumer acknowledges, then captures the layer result.
module fc84_vector_loader #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64,
  parameter int N         = 84
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BIT_WIDTH-1:0]       s_data,
  input  logic [BIT_WIDTH-1:0]       s_weight,
  input  logic                       s_last,
  output logic [BIT_WIDTH*N-1:0]     in_vec,
  output logic [BIT_WIDTH*N-1:0]     w_vec,
  output logic                       vec_valid,
  input  logic                       vec_ack,
  input  logic [OUT_WIDTH-1:0]       fc_out,
  output logic [OUT_WIDTH-1:0]       result,
  output logic                       result_valid,
  output logic                       frame_err,
  output logic [$clog2(N+1)-1:0]     fill_cnt
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t state, next_state;

  logic [BIT_WIDTH-1:0] in_mem [N];
  logic [BIT_WIDTH-1:0] w_mem  [N];

  logic at_last_slot;
  logic beat_ok;
  logic beat_bad;
  logic ack_take;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state   = state;
    at_last_slot = (fill_cnt == LAST_K);
    beat_ok      = 1'b0;
    beat_bad     = 1'b0;
    ack_take     = 1'b0;
    unique case (state)
      LOAD: begin
        // s_last must coincide exactly with the final slot; anything else is a framing error.
        beat_bad = s_valid && (s_last != at_last_slot);
        beat_ok  = s_valid && !beat_bad;
        if (beat_ok && at_last_slot) next_state = FULL;
      end
      FULL: begin
        ack_take = vec_ack;
        if (vec_ack) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  assign s_ready   = (state == LOAD);
  assign vec_valid = (state == FULL);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (beat_ok)  fill_cnt <= fill_cnt + 1'b1;
      if (beat_bad) begin
        fill_cnt  <= '0;
        frame_err <= 1'b1;
      end
      if (ack_take) begin
        result       <= fc_out;
        result_valid <= 1'b1;
        fill_cnt     <= '0;
      end
    end
  end

  // NOTE: the slot storage is reset on purpose because the flattened vectors must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        in_mem[k] <= '0;
        w_mem[k]  <= '0;
      end
    end else if (beat_ok) begin
      in_mem[fill_cnt] <= s_data;
      w_mem[fill_cnt]  <= s_weight;
    end
  end

  // Slot k occupies bits [BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k] of each flattened vector.
  always_comb begin
    in_vec = '0;
    w_vec  = '0;
    for (int k = 0; k < N; k++) begin
      in_vec[k*BIT_WIDTH +: BIT_WIDTH] = in_mem[k];
      w_vec[k*BIT_WIDTH +: BIT_WIDTH]  = w_mem[k];
    end
  end

endmodule

// File: tb/tb_fc84_vector_loader.sv
// Directed bench for fc84_vector_loader: a reference model tracks slot contents and
// fill count, and a scoreboard queue holds the results expected on each FULL acknowledge.
module tb_fc84_vector_loader;

  localparam int BW = 32;
  localparam int OW = 64;
  localparam int N  = 84;
  localparam logic [OW-1:0] SUM_NEG = -64'sd194054;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [BW-1:0]    s_data = '0;
  logic [BW-1:0]    s_weight = '0;
  logic             s_last = 1'b0;
  logic [BW*N-1:0]  in_vec;
  logic [BW*N-1:0]  w_vec;
  logic             vec_valid;
  logic             vec_ack = 1'b0;
  logic [OW-1:0]    fc_out = '0;
  logic [OW-1:0]    result;
  logic             result_valid;
  logic             frame_err;
  logic [6:0]       fill_cnt;

  fc84_vector_loader #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_weight(s_weight), .s_last(s_last),
    .in_vec(in_vec), .w_vec(w_vec), .vec_valid(vec_valid), .vec_ack(vec_ack),
    .fc_out(fc_out), .result(result), .result_valid(result_valid),
    .frame_err(frame_err), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [BW*N-1:0] exp_in = '0;
  logic [BW*N-1:0] exp_w  = '0;
  int              m_fill = 0;
  bit              m_full = 1'b0;
  logic [OW-1:0]   m_result = '0;
  logic [OW-1:0]   sb_q [$];
  int              exp_rv = 0;
  int              exp_fe = 0;
  int              rv_seen = 0;
  int              fe_seen = 0;

  // Pulses are counted on the rising edge, where the pre-edge output values are stable.
  always @(posedge clk) begin
    if (result_valid === 1'b1) rv_seen++;
    if (frame_err === 1'b1)    fe_seen++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag);
    int slot = -1;
    total++;
    assert (in_vec === exp_in && w_vec === exp_w) else begin
      bad++;
      for (int k = 0; k < N; k++)
        if (slot < 0 && (in_vec[k*BW +: BW] !== exp_in[k*BW +: BW] || w_vec[k*BW +: BW] !== exp_w[k*BW +: BW]))
          slot = k;
      if (slot < 0) slot = 0;
      $error("FAIL %s slot=%0d in observed=%h expected=%h w observed=%h expected=%h", tag, slot,
             in_vec[slot*BW +: BW], exp_in[slot*BW +: BW], w_vec[slot*BW +: BW], exp_w[slot*BW +: BW]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one beat for one cycle while the loader is in LOAD, updating the model.
  task automatic beat(input logic [BW-1:0] d, input logic [BW-1:0] w, input logic last, input int gap);
    idle(gap);
    s_valid  = 1'b1;
    s_data   = d;
    s_weight = w;
    s_last   = last;
    if (last != (m_fill == N - 1)) begin
      m_fill = 0;
      exp_fe++;
    end else begin
      exp_in[m_fill*BW +: BW] = d;
      exp_w[m_fill*BW +: BW]  = w;
      m_fill++;
      if (m_fill == N) m_full = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic load_vec(input bit random_data, input bit gaps);
    logic [BW-1:0] d, w;
    for (int i = 0; i < N; i++) begin
      d = random_data ? $urandom : BW'(i);
      w = random_data ? $urandom : -BW'(i);
      beat(d, w, i == N - 1, gaps ? int'($urandom_range(0, 2)) : 0);
      if (i == 0) check("fill_first_beat", 64'(fill_cnt), 64'(1));
    end
  endtask

  task automatic expect_full(input string tag);
    check({tag, "_vec_valid"}, 64'(vec_valid), 64'(1));
    check({tag, "_s_ready"},   64'(s_ready),   64'(0));
    check({tag, "_fill_cnt"},  64'(fill_cnt),  64'(N));
    check_vec({tag, "_vectors"});
  endtask

  task automatic ack_full(input logic [OW-1:0] val);
    bit found = 1'b0;
    vec_ack = 1'b1;
    fc_out  = val;
    sb_q.push_back(val);
    exp_rv++;
    m_full   = 1'b0;
    m_fill   = 0;
    m_result = val;
    @(negedge clk);
    vec_ack = 1'b0;
    fc_out  = {$urandom, $urandom};
    check("ack_s_ready_next", 64'(s_ready),   64'(1));
    check("ack_vec_valid",    64'(vec_valid), 64'(0));
    check("ack_fill_cnt",     64'(fill_cnt),  64'(0));
    for (int i = 0; i < 4 && !found; i++) begin
      if (result_valid === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check("result_valid_seen", 64'(found), 64'(1));
    if (sb_q.size() > 0) check("result_value", result, sb_q.pop_front());
  endtask

  task automatic ack_in_load(input logic [OW-1:0] val);
    vec_ack = 1'b1;
    fc_out  = val;
    @(negedge clk);
    vec_ack = 1'b0;
    check("load_ack_no_pulse", 64'(result_valid), 64'(0));
    check("load_ack_result",   result,            m_result);
    check("load_ack_s_ready",  64'(s_ready),      64'(1));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    exp_in   = '0;
    exp_w    = '0;
    m_fill   = 0;
    m_full   = 1'b0;
    m_result = '0;
    check({tag, "_s_ready"},      64'(s_ready),      64'(1));
    check({tag, "_vec_valid"},    64'(vec_valid),    64'(0));
    check({tag, "_fill_cnt"},     64'(fill_cnt),     64'(0));
    check({tag, "_result"},       result,            64'(0));
    check({tag, "_result_valid"}, 64'(result_valid), 64'(0));
    check({tag, "_frame_err"},    64'(frame_err),    64'(0));
    check_vec({tag, "_vectors"});
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_pulses(input string tag);
    idle(1);
    check({tag, "_rv_count"}, 64'(rv_seen), 64'(exp_rv));
    check({tag, "_fe_count"}, 64'(fe_seen), 64'(exp_fe));
  endtask

  initial begin
    // Power-on reset.
    repeat (2) @(negedge clk);
    check("rst_s_ready",      64'(s_ready),      64'(1));
    check("rst_vec_valid",    64'(vec_valid),    64'(0));
    check("rst_fill_cnt",     64'(fill_cnt),     64'(0));
    check("rst_result",       result,            64'(0));
    check("rst_result_valid", 64'(result_valid), 64'(0));
    check("rst_frame_err",    64'(frame_err),    64'(0));
    check_vec("rst_vectors");
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp vector, data=i and weight=-i, result is -(sum i^2).
    load_vec(1'b0, 1'b0);
    expect_full("ramp");
    ack_full(SUM_NEG);
    check_pulses("ramp");

    // Random gaps, consumer stalls 10 cycles while junk beats are offered.
    load_vec(1'b1, 1'b1);
    expect_full("stall_entry");
    for (int c = 0; c < 10; c++) begin
      s_valid  = 1'b1;
      s_data   = $urandom;
      s_weight = $urandom;
      s_last   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stall_s_ready",  64'(s_ready),  64'(0));
      check("stall_fill_cnt", 64'(fill_cnt), 64'(N));
      check_vec("stall_vectors");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    ack_full({$urandom, $urandom});
    idle(1);
    check("stall_junk_not_taken", 64'(fill_cnt), 64'(0));
    check_pulses("stall");

    // Early s_last on beat 40, then a clean vector.
    for (int i = 0; i < 40; i++) beat(BW'(1000 + i), BW'(2000 + i), 1'b0, 0);
    beat(32'hdead_0040, 32'hbeef_0040, 1'b1, 0);
    check("early_frame_err", 64'(frame_err), 64'(1));
    check("early_fill_cnt",  64'(fill_cnt),  64'(0));
    check("early_vec_valid", 64'(vec_valid), 64'(0));
    idle(1);
    check("early_err_single", 64'(frame_err), 64'(0));
    check_vec("early_slots_kept");
    load_vec(1'b1, 1'b0);
    expect_full("after_early");
    ack_full({$urandom, $urandom});
    check_pulses("early");

    // Missing s_last on beat 83.
    for (int i = 0; i < N - 1; i++) beat($urandom, $urandom, 1'b0, 0);
    beat(32'h1234_5678, 32'h8765_4321, 1'b0, 0);
    check("late_frame_err", 64'(frame_err), 64'(1));
    check("late_fill_cnt",  64'(fill_cnt),  64'(0));
    check("late_vec_valid", 64'(vec_valid), 64'(0));
    idle(1);
    check("late_no_full", 64'(vec_valid), 64'(0));
    check_vec("late_slots_kept");
    check_pulses("late");

    // Ack in LOAD is ignored, both idle and mid-vector.
    ack_in_load({$urandom, $urandom});
    for (int i = 0; i < 5; i++) beat($urandom, $urandom, 1'b0, 0);
    ack_in_load({$urandom, $urandom});
    check("load_ack_fill_kept", 64'(fill_cnt), 64'(5));

    // Reset after 50 beats, then reset while FULL, then a vector from slot 0.
    for (int i = 5; i < 50; i++) beat($urandom, $urandom, 1'b0, 0);
    check("pre_reset_fill", 64'(fill_cnt), 64'(50));
    do_reset("rst_mid");
    check_pulses("rst_mid");
    load_vec(1'b0, 1'b1);
    expect_full("pre_rst_full");
    do_reset("rst_full");
    check_pulses("rst_full");
    load_vec(1'b1, 1'b1);
    expect_full("post_rst");
    ack_full({$urandom, $urandom});
    check_pulses("final");
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
